// File: rtl/noc_params.sv
// Network-wide parameters and flit format shared by every router block.
package noc_params;

  localparam int PORT_NUM       = 5;
  localparam int VC_NUM         = 2;
  localparam int BUFFER_SIZE    = 4;
  localparam int VC_SIZE        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int FLIT_DATA_SIZE = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t                flit_label;
    logic [VC_SIZE-1:0]         vc_id;
    logic [FLIT_DATA_SIZE-1:0]  data;
  } flit_t;

endpackage

// File: rtl/output_port_pkg.sv
// Local types for the output port: per-VC packet-tracking state.
package output_port_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_t;

endpackage

// File: rtl/output_port_vc_tracker.sv
// Tracks one downstream VC: credit count plus packet-boundary state machine.
// Latency: count/state update on the clock edge after send or credit.
// Backpressure: none here; credit_avail/vc_free are consumed by the allocators.
module output_vc_tracker
  import output_port_pkg::*;
#(
  parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send,
  input  noc_params::flit_label_t label,
  input  logic                    credit,
  output logic                    credit_avail,
  output logic                    vc_free,
  output logic                    error
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  logic [CW-1:0] count, count_nxt;
  vc_state_t     state, state_nxt;
  logic          cnt_err, fsm_err;

  // A send and a credit in the same cycle cancel, even at either boundary.
  always_comb begin
    count_nxt = count;
    cnt_err   = 1'b0;
    case ({send, credit})
      2'b10: begin
        if (count == '0) cnt_err   = 1'b1;
        else             count_nxt = count - CW'(1);
      end
      2'b01: begin
        if (count == FULL) cnt_err   = 1'b1;
        else               count_nxt = count + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    fsm_err   = 1'b0;
    if (send) begin
      case (state)
        IDLE: begin
          case (label)
            noc_params::HEAD:     state_nxt = ACTIVE;
            noc_params::HEADTAIL: state_nxt = IDLE;
            default:              fsm_err   = 1'b1;
          endcase
        end
        ACTIVE: begin
          case (label)
            noc_params::TAIL: state_nxt = IDLE;
            noc_params::BODY: state_nxt = ACTIVE;
            default:          fsm_err   = 1'b1;
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= FULL;
      state <= IDLE;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  // Reuse only once the previous packet is closed and fully drained downstream.
  assign credit_avail = (count != '0);
  assign vc_free      = (state == IDLE) && (count == FULL);
  assign error        = cnt_err | fsm_err;

endmodule

// File: rtl/output_port.sv
// Router output port: registers the crossbar flit onto the link and tracks downstream VCs.
// Latency: one cycle flit_i->flit_o; status outputs come from registered state only.
// Backpressure: credit-based; allocators must gate sends on credit_avail_o/vc_free_o.
module output_port #(
  parameter int VC_NUM      = noc_params::VC_NUM,
  parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  noc_params::flit_t flit_i,
  input  logic              valid_i,
  input  logic [VC_NUM-1:0] credit_i,
  output noc_params::flit_t flit_o,
  output logic              valid_o,
  output logic [VC_NUM-1:0] credit_avail_o,
  output logic [VC_NUM-1:0] vc_free_o,
  output logic              error_o
);

  logic [VC_NUM-1:0] send;
  logic [VC_NUM-1:0] vc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_o  <= '0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) flit_o <= flit_i;
      error_o <= error_o | (|vc_err);
    end
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : gen_vc
    assign send[v] = valid_i && (flit_i.vc_id == noc_params::VC_SIZE'(v));

    output_vc_tracker #(
      .BUFFER_SIZE (BUFFER_SIZE)
    ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .send         (send[v]),
      .label        (flit_i.flit_label),
      .credit       (credit_i[v]),
      .credit_avail (credit_avail_o[v]),
      .vc_free      (vc_free_o[v]),
      .error        (vc_err[v])
    );
  end

endmodule

// File: tb/tb_output_port.sv
// Table-driven bench for output_port with a flit scoreboard (VC_NUM=2, BUFFER_SIZE=4).
module tb_output_port;
  import noc_params::*;

  logic       clk;
  logic       rst;
  flit_t      flit_i;
  logic       valid_i;
  logic [1:0] credit_i;
  flit_t      flit_o;
  logic       valid_o;
  logic [1:0] credit_avail_o;
  logic [1:0] vc_free_o;
  logic       error_o;

  output_port #(.VC_NUM(2), .BUFFER_SIZE(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_i         (flit_i),
    .valid_i        (valid_i),
    .credit_i       (credit_i),
    .flit_o         (flit_o),
    .valid_o        (valid_o),
    .credit_avail_o (credit_avail_o),
    .vc_free_o      (vc_free_o),
    .error_o        (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    flit_label_t lbl;
    logic        vc;
    logic [1:0]  cred;
    logic [1:0]  ca;
    logic [1:0]  vf;
    logic        err;
  } vec_t;

  typedef struct {
    logic  vld;
    flit_t flit;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic vld, input flit_label_t lbl, input logic vc,
                     input logic [1:0] cred, input logic [1:0] ca, input logic [1:0] vf,
                     input logic err);
    vec_t v;
    v.rst = r; v.vld = vld; v.lbl = lbl; v.vc = vc; v.cred = cred;
    v.ca = ca; v.vf = vf; v.err = err;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t  v;
    exp_t  e;
    flit_t f;
    flit_t last;

    rst = 1'b1; valid_i = 1'b0; credit_i = 2'b00; flit_i = '0; last = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_flit", 32'(flit_o), 32'd0);
    chk("reset_credit_avail", 32'(credit_avail_o), 32'h3);
    chk("reset_vc_free", 32'(vc_free_o), 32'h3);
    chk("reset_error", 32'(error_o), 32'd0);
    rst = 1'b0;

    //    rst vld label     vc cred    ca     vf     err
    add(0, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);  // idle x3
    add(0, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);
    add(0, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);
    add(0, 1, HEAD,     0, 2'b00, 2'b11, 2'b10, 0);  // VC0 packet
    add(0, 1, BODY,     0, 2'b00, 2'b11, 2'b10, 0);
    add(0, 1, TAIL,     0, 2'b00, 2'b11, 2'b10, 0);
    add(0, 0, HEAD,     0, 2'b01, 2'b11, 2'b10, 0);  // return credits
    add(0, 0, HEAD,     0, 2'b01, 2'b11, 2'b10, 0);
    add(0, 0, HEAD,     0, 2'b01, 2'b11, 2'b11, 0);
    add(0, 1, HEADTAIL, 0, 2'b00, 2'b11, 2'b10, 0);  // single-flit packet
    add(0, 0, HEAD,     0, 2'b01, 2'b11, 2'b11, 0);
    add(0, 1, HEAD,     1, 2'b00, 2'b11, 2'b01, 0);  // drain VC1
    add(0, 1, BODY,     1, 2'b00, 2'b11, 2'b01, 0);
    add(0, 1, BODY,     1, 2'b00, 2'b11, 2'b01, 0);
    add(0, 1, BODY,     1, 2'b00, 2'b01, 2'b01, 0);
    add(0, 1, BODY,     1, 2'b00, 2'b01, 2'b01, 1);  // send with no credit
    add(1, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);
    add(0, 1, HEAD,     0, 2'b00, 2'b11, 2'b10, 0);
    add(0, 1, BODY,     0, 2'b00, 2'b11, 2'b10, 0);
    add(0, 1, BODY,     0, 2'b01, 2'b11, 2'b10, 0);  // send+credit cancel
    add(0, 0, HEAD,     0, 2'b11, 2'b11, 2'b10, 1);  // credit into full VC1
    add(0, 1, TAIL,     0, 2'b00, 2'b11, 2'b10, 1);
    add(0, 1, HEADTAIL, 0, 2'b00, 2'b11, 2'b10, 1);
    add(0, 1, HEADTAIL, 0, 2'b00, 2'b10, 2'b10, 1);  // count0 reaches zero
    add(0, 0, HEAD,     0, 2'b01, 2'b11, 2'b10, 1);
    add(1, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);
    add(0, 1, HEAD,     1, 2'b00, 2'b11, 2'b01, 0);  // reset mid-packet
    add(0, 1, BODY,     1, 2'b00, 2'b11, 2'b01, 0);
    add(1, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);
    add(0, 0, HEAD,     0, 2'b10, 2'b11, 2'b11, 1);  // count1 restored to full
    add(1, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);
    add(0, 1, BODY,     1, 2'b00, 2'b11, 2'b01, 1);  // FSM1 restored to IDLE
    add(1, 0, HEAD,     0, 2'b00, 2'b11, 2'b11, 0);
    add(0, 1, HEADTAIL, 1, 2'b00, 2'b11, 2'b01, 0);
    add(0, 1, HEAD,     0, 2'b00, 2'b11, 2'b00, 0);
    add(0, 1, HEAD,     0, 2'b00, 2'b11, 2'b00, 1);  // HEAD while ACTIVE
    add(0, 1, TAIL,     0, 2'b00, 2'b11, 2'b00, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.rst) begin
        valid_i = 1'b0; credit_i = 2'b00; rst = 1'b1;
        last = '0;
        e.vld = 1'b0; e.flit = '0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        f.flit_label = v.lbl;
        f.vc_id      = v.vc;
        f.data       = 16'($urandom);
        flit_i   = f;
        valid_i  = v.vld;
        credit_i = v.cred;
        if (v.vld) last = f;
        e.vld = v.vld; e.flit = last;
        sbq.push_back(e);
        @(posedge clk);
        #1;
      end
      e = sbq.pop_front();
      chk($sformatf("row%0d_valid_o", i), 32'(valid_o), 32'(e.vld));
      chk($sformatf("row%0d_flit_o", i), 32'(flit_o), 32'(e.flit));
      chk($sformatf("row%0d_credit_avail_o", i), 32'(credit_avail_o), 32'(v.ca));
      chk($sformatf("row%0d_vc_free_o", i), 32'(vc_free_o), 32'(v.vf));
      chk($sformatf("row%0d_error_o", i), 32'(error_o), 32'(v.err));
    end

    // Asynchronous reset mid-cycle must drop a registered flit immediately.
    f.flit_label = HEAD; f.vc_id = 1'b0; f.data = 16'hBEEF;
    flit_i = f; valid_i = 1'b1; credit_i = 2'b00;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("async_pre_valid", 32'(valid_o), 32'd1);
    chk("async_pre_flit", 32'(flit_o), 32'(f));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_valid_drop", 32'(valid_o), 32'd0);
    chk("async_flit_clear", 32'(flit_o), 32'd0);
    chk("async_vc_free", 32'(vc_free_o), 32'h3);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
